// File: rtl/bbq_pingpong_ctrl.sv
// Ping-pong sequencer for the two BBQ priority queues: one PQ fills while the
// other drains, with roles swapped on occupancy and minimum-phase-time rules.
module bbq_pingpong_ctrl #(
    parameter int DWIDTH      = 32,
    parameter int PWIDTH      = 6,
    parameter int PQ_CAPACITY = 64,
    parameter int CREDITS     = 16,
    parameter int MIN_PHASE   = 11,
    localparam int CW         = $clog2(PQ_CAPACITY + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic [PWIDTH-1:0] in_prior,
    input  logic [1:0]        pq_rdy,
    output logic              pq0_valid,
    output logic [1:0]        pq0_op,
    output logic [DWIDTH-1:0] pq0_data,
    output logic [PWIDTH-1:0] pq0_prior,
    output logic              pq1_valid,
    output logic [1:0]        pq1_op,
    output logic [DWIDTH-1:0] pq1_data,
    output logic [PWIDTH-1:0] pq1_prior,
    input  logic              credit_ret,
    output logic              fill_sel,
    output logic [CW-1:0]     occ0,
    output logic [CW-1:0]     occ1,
    output logic              ready
);

    localparam int KW = $clog2(CREDITS + 1);
    localparam int TW = (MIN_PHASE > 1) ? $clog2(MIN_PHASE) : 1;

    localparam logic [1:0] HEAP_OP_ENQUE     = 2'b00;
    localparam logic [1:0] HEAP_OP_DEQUE_MAX = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_SWAP = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     fill_q, fill_d;
    logic                     ready_q, ready_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic [KW-1:0]            credits_q, credits_d;
    logic [1:0][CW-1:0]       occ_q, occ_d;
    logic [1:0]               valid_q, valid_d;
    logic [1:0][1:0]          op_q, op_d;
    logic [1:0][DWIDTH-1:0]   data_q, data_d;
    logic [1:0][PWIDTH-1:0]   prior_q, prior_d;

    logic                     drain_sel;
    logic [CW-1:0]            occ_fill, occ_drain;
    logic                     fill_full, timer_done, swap_cond;
    logic                     in_ready_w, enq, deq;

    assign drain_sel  = ~fill_q;
    assign occ_fill   = occ_q[fill_q];
    assign occ_drain  = occ_q[drain_sel];
    assign fill_full  = (occ_fill == CW'(PQ_CAPACITY));
    assign timer_done = (timer_q == TW'(MIN_PHASE - 1));

    // Swap only once the drain side is empty, so no op is ever lost to a role change.
    assign swap_cond  = (state_q == ST_RUN) && (occ_drain == '0) && (occ_fill != '0)
                        && (timer_done || fill_full);
    assign in_ready_w = (state_q == ST_RUN) && !fill_full && !swap_cond;
    assign enq        = in_valid && in_ready_w;
    assign deq        = (state_q == ST_RUN) && (occ_drain != '0) && (credits_q != '0);

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        ready_d   = ready_q;
        timer_d   = timer_q;
        credits_d = credits_q;
        occ_d     = occ_q;
        valid_d   = 2'b00;
        op_d      = op_q;
        data_d    = data_q;
        prior_d   = prior_q;

        case (state_q)
            ST_INIT: begin
                if (pq_rdy == 2'b11) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!timer_done) timer_d = timer_q + TW'(1);
                if (swap_cond) state_d = ST_SWAP;
                if (enq) begin
                    valid_d[fill_q] = 1'b1;
                    op_d[fill_q]    = HEAP_OP_ENQUE;
                    data_d[fill_q]  = in_data;
                    prior_d[fill_q] = in_prior;
                    occ_d[fill_q]   = occ_q[fill_q] + CW'(1);
                end
                if (deq) begin
                    valid_d[drain_sel] = 1'b1;
                    op_d[drain_sel]    = HEAP_OP_DEQUE_MAX;
                    occ_d[drain_sel]   = occ_q[drain_sel] - CW'(1);
                end
            end
            ST_SWAP: begin
                fill_d  = ~fill_q;
                timer_d = '0;
                state_d = ST_RUN;
            end
            default: state_d = ST_INIT;
        endcase

        // A return at full credit is dropped; issue plus return cancel out.
        case ({deq, credit_ret})
            2'b10:   credits_d = credits_q - KW'(1);
            2'b01:   if (credits_q != KW'(CREDITS)) credits_d = credits_q + KW'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_INIT;
            fill_q    <= 1'b0;
            ready_q   <= 1'b0;
            timer_q   <= '0;
            credits_q <= KW'(CREDITS);
            occ_q     <= '0;
            valid_q   <= 2'b00;
            op_q      <= {HEAP_OP_ENQUE, HEAP_OP_ENQUE};
            data_q    <= '0;
            prior_q   <= '0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            ready_q   <= ready_d;
            timer_q   <= timer_d;
            credits_q <= credits_d;
            occ_q     <= occ_d;
            valid_q   <= valid_d;
            op_q      <= op_d;
            data_q    <= data_d;
            prior_q   <= prior_d;
        end
    end

    assign in_ready  = in_ready_w;
    assign pq0_valid = valid_q[0];
    assign pq0_op    = op_q[0];
    assign pq0_data  = data_q[0];
    assign pq0_prior = prior_q[0];
    assign pq1_valid = valid_q[1];
    assign pq1_op    = op_q[1];
    assign pq1_data  = data_q[1];
    assign pq1_prior = prior_q[1];
    assign fill_sel  = fill_q;
    assign occ0      = occ_q[0];
    assign occ1      = occ_q[1];
    assign ready     = ready_q;

endmodule

// File: tb/tb_bbq_pingpong_ctrl.sv
// Bench for bbq_pingpong_ctrl: directed and random traffic checked every cycle
// against a queue-based model of the two PQs and the output-FIFO credit pool.
module tb_bbq_pingpong_ctrl;

    localparam int DW   = 32;
    localparam int PW   = 6;
    localparam int CAP  = 6;
    localparam int CRED = 4;
    localparam int MINP = 11;
    localparam int CW   = $clog2(CAP + 1);

    localparam logic [1:0] OP_ENQ = 2'b00;
    localparam logic [1:0] OP_DEQ = 2'b10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [PW-1:0] in_prior = '0;
    logic [1:0]    pq_rdy = 2'b00;
    logic          pq0_valid, pq1_valid;
    logic [1:0]    pq0_op, pq1_op;
    logic [DW-1:0] pq0_data, pq1_data;
    logic [PW-1:0] pq0_prior, pq1_prior;
    logic          credit_ret = 1'b0;
    logic          fill_sel;
    logic [CW-1:0] occ0, occ1;
    logic          ready;

    bbq_pingpong_ctrl #(
        .DWIDTH(DW), .PWIDTH(PW), .PQ_CAPACITY(CAP), .CREDITS(CRED), .MIN_PHASE(MINP)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_prior(in_prior),
        .pq_rdy(pq_rdy),
        .pq0_valid(pq0_valid), .pq0_op(pq0_op), .pq0_data(pq0_data), .pq0_prior(pq0_prior),
        .pq1_valid(pq1_valid), .pq1_op(pq1_op), .pq1_data(pq1_data), .pq1_prior(pq1_prior),
        .credit_ret(credit_ret), .fill_sel(fill_sel), .occ0(occ0), .occ1(occ1), .ready(ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: PQ contents as queues, credits as free output-FIFO slots,
    // phase = waiting / running / swapping, age = RUN cycles since last role change.
    logic [DW-1:0] mq0[$];
    logic [DW-1:0] mq1[$];
    int m_phase, m_cred, m_age, m_fill;
    bit m_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        m_phase = 0;
        m_cred  = CRED;
        m_age   = 0;
        m_fill  = 0;
        m_ready = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_fill_sel"}, fill_sel, 0);
        chk({tag, "_occ0"}, occ0, 0);
        chk({tag, "_occ1"}, occ1, 0);
        chk({tag, "_pq0_valid"}, pq0_valid, 0);
        chk({tag, "_pq1_valid"}, pq1_valid, 0);
        chk({tag, "_pq0_op"}, pq0_op, OP_ENQ);
        chk({tag, "_pq1_op"}, pq1_op, OP_ENQ);
        chk({tag, "_pq0_data"}, pq0_data, 0);
        chk({tag, "_pq1_data"}, pq1_data, 0);
        chk({tag, "_pq0_prior"}, pq0_prior, 0);
        chk({tag, "_pq1_prior"}, pq1_prior, 0);
    endtask

    // One clock cycle: drive inputs, check in_ready mid-cycle, advance model, check outputs.
    task automatic step(input bit v, input logic [DW-1:0] d, input logic [PW-1:0] p,
                        input logic [1:0] rdy, input bit ret);
        int of, od, f;
        bit running, swap_now, exp_rdy, enq, deq;
        bit e_valid [2];
        logic [1:0]    e_op [2];
        logic [DW-1:0] e_data [2];
        logic [PW-1:0] e_prior [2];
        logic [DW-1:0] dropped;

        in_valid = v; in_data = d; in_prior = p; pq_rdy = rdy; credit_ret = ret;
        @(negedge clk);
        f        = m_fill;
        of       = (f == 0) ? mq0.size() : mq1.size();
        od       = (f == 0) ? mq1.size() : mq0.size();
        running  = (m_phase == 1);
        swap_now = running && od == 0 && of > 0 && (m_age >= MINP - 1 || of == CAP);
        exp_rdy  = running && of < CAP && !swap_now;
        chk("in_ready", in_ready, exp_rdy);
        enq = v && exp_rdy;
        deq = running && od > 0 && m_cred > 0;

        @(posedge clk);
        #1;
        e_valid[0] = 0; e_valid[1] = 0;
        e_op[0] = OP_ENQ; e_op[1] = OP_ENQ;
        e_data[0] = '0; e_data[1] = '0;
        e_prior[0] = '0; e_prior[1] = '0;
        if (enq) begin
            if (f == 0) mq0.push_back(d); else mq1.push_back(d);
            e_valid[f] = 1; e_op[f] = OP_ENQ; e_data[f] = d; e_prior[f] = p;
        end
        if (deq) begin
            if (f == 0) dropped = mq1.pop_front(); else dropped = mq0.pop_front();
            e_valid[1-f] = 1; e_op[1-f] = OP_DEQ;
        end
        m_cred = m_cred - int'(deq) + int'(ret);
        if (m_cred > CRED) m_cred = CRED;
        case (m_phase)
            0: if (rdy == 2'b11) begin m_phase = 1; m_ready = 1; end
            1: begin m_age++; if (swap_now) m_phase = 2; end
            default: begin m_fill = 1 - m_fill; m_age = 0; m_phase = 1; end
        endcase

        chk("pq0_valid", pq0_valid, e_valid[0]);
        chk("pq1_valid", pq1_valid, e_valid[1]);
        if (e_valid[0]) begin
            chk("pq0_op", pq0_op, e_op[0]);
            if (e_op[0] == OP_ENQ) begin
                chk("pq0_data", pq0_data, e_data[0]);
                chk("pq0_prior", pq0_prior, e_prior[0]);
            end
        end
        if (e_valid[1]) begin
            chk("pq1_op", pq1_op, e_op[1]);
            if (e_op[1] == OP_ENQ) begin
                chk("pq1_data", pq1_data, e_data[1]);
                chk("pq1_prior", pq1_prior, e_prior[1]);
            end
        end
        chk("fill_sel", fill_sel, m_fill);
        chk("occ0", occ0, mq0.size());
        chk("occ1", occ1, mq1.size());
        chk("ready", ready, m_ready);
        $display("cyc v=%0b d=%0h rdy=%0b ret=%0b | in_ready=%0b v0=%0b v1=%0b fill=%0b occ0=%0d occ1=%0d",
                 v, d, rdy, ret, exp_rdy, pq0_valid, pq1_valid, fill_sel, occ0, occ1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // INIT: requests refused until both PQs report ready
        for (int i = 0; i < 4; i++) step(1, 32'h99, 6'd1, 2'b01, 0);
        step(0, 0, 0, 2'b11, 0);

        // Three enqueues into PQ0, idle through the minimum phase, swap, drain PQ0
        step(1, 32'hA, 6'd10, 2'b11, 0);
        step(1, 32'hB, 6'd11, 2'b11, 0);
        step(1, 32'hC, 6'd12, 2'b11, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 2'b11, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b11, 1);

        // Credit-limited drain with a full fill PQ, then returns that re-enable deques
        for (int i = 0; i < 4; i++) step(0, 0, 0, 2'b11, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b11, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b11, 0);
        for (int i = 0; i < 14; i++) step(1, 32'h100 + i, 6'(i), 2'b11, 0);
        for (int i = 0; i < 12; i++) step(1, 32'h200 + i, 6'(i), 2'b11, (i % 3) != 2);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 2'b11, 1);

        // Random traffic, pq_rdy ignored after INIT
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, $urandom, 6'($urandom), 2'($urandom),
                 $urandom_range(0, 2) == 0);

        // Asynchronous reset mid-stream
        rst = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        pq_rdy = 2'b00; in_valid = 1'b0; credit_ret = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1, 32'h55, 6'd5, 2'b10, 0);
        step(1, 32'h56, 6'd6, 2'b11, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom, 6'($urandom), 2'b11,
                 $urandom_range(0, 3) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bbq_pingpong_ctrl.md
Name: bbq_pingpong_ctrl

Overview:
- Sequences the two BBQ priority queues of the packet scheduler as a ping-pong pair. One PQ (the "fill" PQ) takes enqueues while the other (the "drain" PQ) is emptied by DEQUE_MAX ops.
- Roles swap on occupancy and phase-time rules, replacing a free-running toggle counter.
- Sits between the priority calculator (upstream) and the two bbq instances and output FIFO (downstream).
- Tracks per-PQ occupancy and output-buffer credits so PQs never underflow or overflow and the output FIFO is never overrun.

Parameters:
DWIDTH, 32, heap-entry data width (buffer address)
PWIDTH, 6, priority width
PQ_CAPACITY, 64, max entries per PQ
CREDITS, 16, output FIFO depth (initial deque credits)
MIN_PHASE, 11, minimum cycles in RUN before a voluntary swap
CW, $clog2(PQ_CAPACITY+1), occupancy counter width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
in_valid  in  1  enqueue request from priority calculator
in_ready  out  1  enqueue accepted when in_valid&&in_ready
in_data  in  DWIDTH  entry data
in_prior  in  PWIDTH  entry priority
pq_rdy  in  2  bit i = bbq i initialised
pq0_valid  out  1  op strobe to PQ0
pq0_op  out  heap_op_t  HEAP_OP_ENQUE or HEAP_OP_DEQUE_MAX
pq0_data  out  DWIDTH  enqueue data
pq0_prior  out  PWIDTH  enqueue priority
pq1_valid, pq1_op, pq1_data, pq1_prior  out  as PQ0
credit_ret  in  1  one pulse per entry removed from the output FIFO
fill_sel  out  1  index of current fill PQ
occ0, occ1  out  CW  occupancy of each PQ
ready  out  1  controller in RUN/SWAP (left INIT)

Behaviour:
- Reset (rst low, async) clears all state:
  - state=INIT, fill_sel=0, occ0=occ1=0, credits=CREDITS, phase timer=0.
  - All pqX_valid=0, pqX_op=HEAP_OP_ENQUE, pqX_data=0, pqX_prior=0.
  - in_ready=0, ready=0.
- Reset mid-operation discards in-flight bookkeeping. The PQs are reset by the same rst.
- All outputs are registered. Each PQ receives at most one op per cycle.
- States:
  - INIT:
    - in_ready=0 and no ops issued.
    - Go to RUN the cycle after pq_rdy==2'b11 is sampled.
    - ready goes 1 on entering RUN and stays 1 until reset.
  - RUN:
    - in_ready = (occ[fill_sel] < PQ_CAPACITY) and no swap is pending. It is combinational from registered state.
    - Enqueue: on in_valid&&in_ready, the next cycle pq[fill_sel]_valid=1, op=ENQUE, data/prior are the captured inputs. occ[fill_sel] increments. Latency is 1 cycle.
    - Dequeue: when occ[~fill_sel]>0 and credits>0, issue pq[~fill_sel] op=DEQUE_MAX with valid=1. occ[~fill_sel] decrements and credits decrements.
    - Enqueue and dequeue may issue in the same cycle because they target different PQs.
    - Phase timer increments each RUN cycle and saturates at MIN_PHASE-1.
    - Swap condition: occ[~fill_sel]==0, occ[fill_sel]>0, and either timer==MIN_PHASE-1 or occ[fill_sel]==PQ_CAPACITY.
    - When the swap condition holds, in_ready=0 that cycle and the next state is SWAP.
  - SWAP:
    - Exactly 1 bubble cycle with no ops and in_ready=0.
    - fill_sel toggles, timer clears, return to RUN.
- Credits:
  - credit_ret increments credits. A simultaneous deque issue and credit_ret leaves credits unchanged.
  - Credits never exceed CREDITS. A credit_ret pulse at CREDITS is ignored.
- Boundary conditions:
  - occ never exceeds PQ_CAPACITY and never goes below 0.
  - No DEQUE is issued to an empty PQ.
  - When both PQs are empty the controller stays in RUN with fill_sel unchanged.
  - When the fill PQ is full and the drain PQ is non-empty, in_ready=0 until the drain PQ empties, then a swap occurs.
- pq_rdy dropping after INIT is not expected. The controller ignores it.

Test Plan:
- Reset, pq_rdy=11 at cycle 5 -> ready=1 at cycle 6; in_ready=0 before cycle 6; all pqX_valid stay 0.
- 3 enqueues (data 0xA,0xB,0xC) in RUN with fill_sel=0 -> pq0_valid pulses 1 cycle after each handshake with op=ENQUE; occ0=3. After MIN_PHASE cycles with occ1=0 -> 1 SWAP bubble, then fill_sel=1.
- After that swap -> 3 DEQUE_MAX to PQ0 on consecutive cycles; occ0 reaches 0; credits 16->13. Three credit_ret pulses -> credits=16.
- CREDITS=2, drain PQ holds 5 -> exactly 2 deques, then stall. Each credit_ret allows exactly 1 more deque. A simultaneous credit_ret and deque holds credits constant.
- PQ_CAPACITY=4, drain PQ holds 2, continuous in_valid -> 4 enqueues accepted, then in_ready=0. After 2 deques the swap occurs and in_ready returns to 1 one cycle after SWAP.
- Assert rst low mid-stream (occ0=5, credits=10) -> all outputs return to reset values asynchronously. After release, INIT waits for pq_rdy again.
